// File: rtl/mips32_pipe.sv
//==============================================================================
// mips32_pipe : 5-stage pipelined MIPS32-subset core, unified word memory
// Forwarding from EX/MEM and MEM/WB, branch resolved in EX / redirected in MEM. Rev 1.0
//==============================================================================
`default_nettype none

module mips32_pipe #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [31:0] Reg [0:31];
  logic [31:0] mem [0:MEM_DEPTH-1];

  logic [31:0] pc_q;
  logic        halted_q;

  // IF/ID
  logic        ifid_valid;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;

  // ID/EX
  logic        idex_valid;
  logic [5:0]  idex_op;
  logic [4:0]  idex_rs, idex_rt, idex_dest;
  logic        idex_we, idex_load, idex_store, idex_branch, idex_hlt;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc;

  // EX/MEM
  logic        exmem_valid;
  logic        exmem_we, exmem_load, exmem_store, exmem_hlt, exmem_taken;
  logic [4:0]  exmem_dest;
  logic [31:0] exmem_alu, exmem_sdata, exmem_target;

  // MEM/WB
  logic        memwb_valid;
  logic        memwb_we, memwb_hlt;
  logic [4:0]  memwb_dest;
  logic [31:0] memwb_val;

  // Decode
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dest;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_rtype, id_ialu, id_load, id_store, id_branch, id_hlt, id_we;
  logic        wb_write;

  assign id_op     = ifid_ir[31:26];
  assign id_rs     = ifid_ir[25:21];
  assign id_rt     = ifid_ir[20:16];
  assign id_rd     = ifid_ir[15:11];
  assign id_imm    = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
  assign id_rtype  = (id_op <= OP_MUL);
  assign id_ialu   = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
  assign id_load   = (id_op == OP_LW);
  assign id_store  = (id_op == OP_SW);
  assign id_branch = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
  assign id_hlt    = (id_op == OP_HLT);
  assign id_dest   = id_rtype ? id_rd : id_rt;
  // Writes to R0 are dropped at decode so forwarding never matches R0.
  assign id_we     = (id_rtype || id_ialu || id_load) && (id_dest != 5'd0);

  assign wb_write  = memwb_valid && memwb_we;
  assign id_a = (id_rs == 5'd0) ? 32'd0 :
                (wb_write && memwb_dest == id_rs) ? memwb_val : Reg[id_rs];
  assign id_b = (id_rt == 5'd0) ? 32'd0 :
                (wb_write && memwb_dest == id_rt) ? memwb_val : Reg[id_rt];

  // Execute with forwarding
  logic [31:0] ex_a, ex_b, ex_alu, ex_target;
  logic        ex_taken, fwd_mem_ok;

  assign fwd_mem_ok = exmem_valid && exmem_we && !exmem_load;

  always_comb begin
    ex_a = idex_a;
    if (fwd_mem_ok && exmem_dest == idex_rs)
      ex_a = exmem_alu;
    else if (wb_write && memwb_dest == idex_rs)
      ex_a = memwb_val;
    ex_b = idex_b;
    if (fwd_mem_ok && exmem_dest == idex_rt)
      ex_b = exmem_alu;
    else if (wb_write && memwb_dest == idex_rt)
      ex_b = memwb_val;
  end

  always_comb begin
    ex_alu = 32'd0;
    case (idex_op)
      OP_ADD:                 ex_alu = ex_a + ex_b;
      OP_SUB:                 ex_alu = ex_a - ex_b;
      OP_AND:                 ex_alu = ex_a & ex_b;
      OP_OR:                  ex_alu = ex_a | ex_b;
      OP_SLT:                 ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:                 ex_alu = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW:  ex_alu = ex_a + idex_imm;
      OP_SUBI:                ex_alu = ex_a - idex_imm;
      OP_SLTI:                ex_alu = {31'd0, $signed(ex_a) < $signed(idex_imm)};
      default:                ex_alu = 32'd0;
    endcase
  end

  assign ex_taken  = idex_branch && ((idex_op == OP_BNEQZ) ? (ex_a != 32'd0) : (ex_a == 32'd0));
  assign ex_target = idex_pc + 32'd1 + idex_imm;

  // Memory stage and fetch control
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_result;
  logic          mem_taken, hlt_in_pipe, fetch_ok;
  logic [31:0]   fetch_addr;

  assign mem_addr   = exmem_alu[AW-1:0];
  assign mem_result = exmem_load ? mem[mem_addr] : exmem_alu;
  assign mem_taken  = exmem_valid && exmem_taken;

  // Any live HLT freezes fetch; a taken branch overrides because it squashes that HLT.
  assign hlt_in_pipe = (ifid_valid && id_hlt) || (idex_valid && idex_hlt) ||
                       (exmem_valid && exmem_hlt) || (memwb_valid && memwb_hlt) || halted_q;
  assign fetch_ok    = mem_taken || !hlt_in_pipe;
  assign fetch_addr  = mem_taken ? exmem_target : pc_q;

  assign pc     = fetch_addr;
  assign halted = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= 32'd0;
      halted_q    <= 1'b0;
      ifid_valid  <= 1'b0;
      idex_valid  <= 1'b0;
      exmem_valid <= 1'b0;
      memwb_valid <= 1'b0;
    end else begin
      if (fetch_ok)
        pc_q <= fetch_addr + 32'd1;
      ifid_valid  <= fetch_ok;
      idex_valid  <= ifid_valid && !mem_taken;
      exmem_valid <= idex_valid && !mem_taken;
      memwb_valid <= exmem_valid;
      if (memwb_valid && memwb_hlt)
        halted_q <= 1'b1;
    end
  end

  // Payload registers; qualified everywhere by the valid bits above.
  always_ff @(posedge clk) begin
    ifid_ir      <= mem[fetch_addr[AW-1:0]];
    ifid_pc      <= fetch_addr;
    idex_op      <= id_op;
    idex_rs      <= id_rs;
    idex_rt      <= id_rt;
    idex_dest    <= id_dest;
    idex_we      <= id_we;
    idex_load    <= id_load;
    idex_store   <= id_store;
    idex_branch  <= id_branch;
    idex_hlt     <= id_hlt;
    idex_a       <= id_a;
    idex_b       <= id_b;
    idex_imm     <= id_imm;
    idex_pc      <= ifid_pc;
    exmem_we     <= idex_we;
    exmem_load   <= idex_load;
    exmem_store  <= idex_store;
    exmem_hlt    <= idex_hlt;
    exmem_taken  <= ex_taken;
    exmem_dest   <= idex_dest;
    exmem_alu    <= ex_alu;
    exmem_sdata  <= ex_b;
    exmem_target <= ex_target;
    memwb_we     <= exmem_we;
    memwb_hlt    <= exmem_hlt;
    memwb_dest   <= exmem_dest;
    memwb_val    <= mem_result;
  end

  always @(posedge clk) begin
    if (wb_write)
      Reg[memwb_dest] <= memwb_val;
    if (exmem_valid && exmem_store)
      mem[mem_addr] <= exmem_sdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_mips32_pipe.sv
//==============================================================================
// tb_mips32_pipe : ISA-level reference model plus per-cycle pc/halted checks. Rev 1.0
//==============================================================================
`default_nettype none

module tb_mips32_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted;
  logic [31:0] pc;

  mips32_pipe #(.MEM_DEPTH(1024)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] prog_mem [1024];
  logic [31:0] m_mem    [1024];
  logic [31:0] m_reg    [32];
  logic [31:0] fetch_q  [$];
  int          hlt_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog_mem[i] = 32'd0;
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      dut.mem[i] = prog_mem[i];
      m_mem[i]   = prog_mem[i];
    end
    for (int k = 0; k < 32; k++) begin
      dut.Reg[k] = 32'(k);
      m_reg[k]   = 32'(k);
    end
  endtask

  function automatic void wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endfunction

  // Instruction-at-a-time interpreter; also records the address fetched each cycle.
  task automatic model_run();
    logic [31:0] p, ir, a, b, imm, addr;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    bit          done;
    int          steps;
    p = 0; done = 0; steps = 0;
    fetch_q.delete();
    hlt_pos = -1;
    while (!done && steps < 4000) begin
      steps++;
      ir  = m_mem[p[9:0]];
      fetch_q.push_back(p);
      op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      imm = {{16{ir[15]}}, ir[15:0]};
      a   = m_reg[rs]; b = m_reg[rt];
      addr = a + imm;
      case (op)
        6'b000000: wr(rd, a + b);
        6'b000001: wr(rd, a - b);
        6'b000010: wr(rd, a & b);
        6'b000011: wr(rd, a | b);
        6'b000100: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'b000101: wr(rd, a * b);
        6'b001000: wr(rt, m_mem[addr[9:0]]);
        6'b001001: m_mem[addr[9:0]] = b;
        6'b001010: wr(rt, a + imm);
        6'b001011: wr(rt, a - imm);
        6'b001100: wr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
        default: ;
      endcase
      if ((op == 6'b001101 && a != 0) || (op == 6'b001110 && a == 0)) begin
        fetch_q.push_back(p + 1);
        fetch_q.push_back(p + 2);
        p = p + 1 + imm;
      end else if (op == 6'b111111) begin
        hlt_pos = fetch_q.size() - 1;
        fetch_q.push_back(p + 1);
        done = 1;
      end else begin
        p = p + 1;
      end
    end
  endtask

  task automatic run(input int stop_at, input bit full, output int first_halt);
    int          limit;
    logic [31:0] exp_pc;
    rst_n = 1'b0;
    @(negedge clk);
    preload();
    model_run();
    @(negedge clk);
    rst_n = 1'b1;
    first_halt = -1;
    limit = (hlt_pos >= 0 && hlt_pos + 8 < stop_at) ? hlt_pos + 8 : stop_at;
    for (int c = 0; c <= limit; c++) begin
      #1;
      exp_pc = (c < fetch_q.size()) ? fetch_q[c] : fetch_q[fetch_q.size() - 1];
      chk($sformatf("pc@cycle%0d", c), pc, exp_pc);
      chk($sformatf("halted@cycle%0d", c), {31'd0, halted},
          (hlt_pos >= 0 && c >= hlt_pos + 5) ? 32'd1 : 32'd0);
      if (halted === 1'b1 && first_halt < 0) first_halt = c;
      if (c < limit) @(negedge clk);
    end
    if (full) begin
      for (int k = 0; k < 32; k++) chk($sformatf("Reg[%0d]", k), dut.Reg[k], m_reg[k]);
      for (int i = 0; i < 1024; i++)
        if (dut.mem[i] !== m_mem[i]) chk($sformatf("mem[%0d]", i), dut.mem[i], m_mem[i]);
        else n_tests++;
    end
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic load_fact();
    clear_prog();
    prog_mem[0] = 32'h280a00c8; prog_mem[1] = 32'h28020001; prog_mem[2]  = 32'h0e94a000;
    prog_mem[3] = 32'h21430000; prog_mem[4] = 32'h0e94a000; prog_mem[5]  = 32'h14431000;
    prog_mem[6] = 32'h2c630001; prog_mem[7] = 32'h0e94a000; prog_mem[8]  = 32'h3460fffc;
    prog_mem[9] = 32'h2542fffe; prog_mem[10] = 32'hfc000000;
    prog_mem[200] = 32'd7;
  endtask

  initial begin
    int fh;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_pc", pc, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);

    // Basic ALU chain with one-instruction gaps
    clear_prog();
    prog_mem[0] = 32'h2801000a; prog_mem[1] = 32'h28020014; prog_mem[2] = 32'h28030019;
    prog_mem[3] = 32'h0ce77800; prog_mem[4] = 32'h0ce77800; prog_mem[5] = 32'h00222000;
    prog_mem[6] = 32'h0ce77800; prog_mem[7] = 32'h00832800; prog_mem[8] = 32'hfc000000;
    run(200, 1'b1, fh);
    chk("t1_R4", dut.Reg[4], 32'd30);
    chk("t1_R5", dut.Reg[5], 32'd55);
    chk("t1_R7", dut.Reg[7], 32'd7);
    chk("t1_halted", {31'd0, halted}, 32'd1);
    async_reset_check("t1_reset_while_halted");

    // Factorial loop
    load_fact();
    run(200, 1'b1, fh);
    chk("t2_mem198", dut.mem[198], 32'd5040);
    chk("t2_mem200", dut.mem[200], 32'd7);
    chk("t2_R2", dut.Reg[2], 32'd5040);
    chk("t2_R3", dut.Reg[3], 32'd0);
    chk("t2_halt_by_90", (fh >= 0 && fh <= 90) ? 32'd1 : 32'd0, 32'd1);

    // Back-to-back dependencies
    clear_prog();
    prog_mem[0] = 32'h28010005; prog_mem[1] = 32'h00211000;
    prog_mem[2] = 32'h04411800; prog_mem[3] = 32'hfc000000;
    run(200, 1'b1, fh);
    chk("t3_R2", dut.Reg[2], 32'd10);
    chk("t3_R3", dut.Reg[3], 32'd5);

    // Taken branch squashes ADDI and HLT on the wrong path
    clear_prog();
    prog_mem[0] = 32'h38000002; prog_mem[1] = 32'h28050001; prog_mem[2] = 32'hfc000000;
    prog_mem[3] = 32'h28070001; prog_mem[4] = 32'hfc000000;
    run(200, 1'b1, fh);
    chk("t4_R5", dut.Reg[5], 32'd5);
    chk("t4_R7", dut.Reg[7], 32'd1);
    chk("t4_first_halt_cycle", 32'(fh), 32'd9);

    // Signed compares and R0
    clear_prog();
    prog_mem[0] = 32'h2c010001; prog_mem[1] = 32'h10201000; prog_mem[2] = 32'h3003fffb;
    prog_mem[3] = 32'h28000009; prog_mem[4] = 32'hfc000000;
    run(200, 1'b1, fh);
    chk("t5_R1", dut.Reg[1], 32'hffffffff);
    chk("t5_R2", dut.Reg[2], 32'd1);
    chk("t5_R3", dut.Reg[3], 32'd0);
    chk("t5_R0", dut.Reg[0], 32'd0);

    // Asynchronous reset in the middle of the factorial run, then a clean rerun
    load_fact();
    run(20, 1'b0, fh);
    async_reset_check("t6_reset_midrun");
    load_fact();
    run(200, 1'b1, fh);
    chk("t6_mem198", dut.mem[198], 32'd5040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
